// File: rtl/bcd_rtc_pkg.sv
`default_nettype none
// ============================================================================
// Package : rtc_pkg
// Shared digit limits, reset time, handshake state type and the BCD
// time-of-day validity check used by the bcd_rtc block.
// Revision: 1.0  initial release
// ============================================================================
package rtc_pkg;

  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] SEC_T_MAX       = 4'd5;
  localparam logic [BCD_W-1:0] UNIT_MAX        = 4'd9;
  localparam logic [BCD_W-1:0] HOUR_MAX_T      = 4'd2;
  localparam logic [BCD_W-1:0] HOUR_MAX_U_AT_2 = 4'd3;

  localparam logic [23:0] RESET_TIME = 24'h000000;

  // Load handshake state; the encoding doubles as the set_ready value.
  typedef enum logic [0:0] {
    LOAD_BUSY  = 1'b0,
    LOAD_READY = 1'b1
  } load_state_t;

  // True when {hh_t,hh_u,mm_t,mm_u,ss_t,ss_u} is a legal 24-hour time.
  function automatic bit bcd_time_valid(input logic [23:0] t);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (t[i*BCD_W +: BCD_W] > UNIT_MAX) ok = 1'b0;
    end
    if (t[7:4]   > SEC_T_MAX)  ok = 1'b0;
    if (t[15:12] > SEC_T_MAX)  ok = 1'b0;
    if (t[23:20] > HOUR_MAX_T) ok = 1'b0;
    if ((t[23:20] == HOUR_MAX_T) && (t[19:16] > HOUR_MAX_U_AT_2)) ok = 1'b0;
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_rtc_if.sv
`default_nettype none
// ============================================================================
// Interface : bcd_rtc_if
// Control, load handshake, alarm and display signals of the BCD clock.
// The clock block is the slave; whoever drives loads and reads the display
// is the master.
// Revision: 1.0  initial release
// ============================================================================
interface bcd_rtc_if;

  logic        run;
  logic        mode_12h;
  logic        set_valid;
  logic        set_ready;
  logic [23:0] set_time;
  logic        set_err;
  logic        alarm_en;
  logic [15:0] alarm_time;
  logic        alarm_hit;
  logic        sec_tick;
  logic [23:0] time_bcd;
  logic        pm;

  modport slave (
    input  run, mode_12h, set_valid, set_time, alarm_en, alarm_time,
    output set_ready, set_err, alarm_hit, sec_tick, time_bcd, pm
  );

  modport master (
    output run, mode_12h, set_valid, set_time, alarm_en, alarm_time,
    input  set_ready, set_err, alarm_hit, sec_tick, time_bcd, pm
  );

endinterface
`default_nettype wire

// File: rtl/bcd_digit_ctr.sv
`default_nettype none
// ============================================================================
// Module  : bcd_digit_ctr
// One BCD digit of the time cascade. Wraps to 0 after its limit and emits a
// combinational carry while incrementing at the limit. The limit is either
// the MAX parameter or, with DYN_MAX set, the max_dyn input.
// Revision: 1.0  initial release
// ============================================================================
module bcd_digit_ctr
  import rtc_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX     = UNIT_MAX,
  parameter bit               DYN_MAX = 1'b0
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             inc,
  input  wire logic             load,
  input  wire logic [BCD_W-1:0] load_val,
  input  wire logic [BCD_W-1:0] max_dyn,
  output logic      [BCD_W-1:0] digit,
  output logic                  carry
);

  logic [BCD_W-1:0] limit;

  assign limit = DYN_MAX ? max_dyn : MAX;
  assign carry = inc & (digit == limit);

  // Load has priority over increment; increment wraps at the limit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digit <= '0;
    end else if (load) begin
      digit <= load_val;
    end else if (inc) begin
      digit <= (digit == limit) ? '0 : digit + BCD_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_rtc.sv
`default_nettype none
// ============================================================================
// Module  : bcd_rtc
// BCD time-of-day counter: prescaler, hh:mm:ss digit cascade, validated
// time-load handshake, 12/24-hour display conversion and alarm compare.
// Revision: 1.0  initial release
// ============================================================================
module bcd_rtc
  import rtc_pkg::*;
#(
  parameter int CLK_DIV = 100000000,
  parameter int DIV_W   = $clog2(CLK_DIV)
) (
  input  wire logic clock,
  input  wire logic reset,
  bcd_rtc_if.slave  bus
);

  load_state_t state, state_nxt;

  logic [DIV_W-1:0] presc;
  logic             ready;
  logic             xfer;
  logic             load_ok;
  logic             wrap;
  logic             inc;

  logic [BCD_W-1:0] ss_u, ss_t, mm_u, mm_t, hh_u, hh_t;
  logic             cy_ss_u, cy_ss_t, cy_mm_u, cy_mm_t, cy_hh_u;
  logic             day_wrap_unused;
  logic [BCD_W-1:0] hh_u_max;
  logic [23:0]      cur_time;

  logic [7:0]       disp_hh;
  logic             disp_pm;
  logic             alarm_ok;

  logic [23:0]      time_bcd_r;
  logic             pm_r, set_err_r, sec_tick_r, alarm_hit_r;

  assign ready    = (state == LOAD_READY);
  assign xfer     = bus.set_valid & ready;
  assign load_ok  = xfer & bcd_time_valid(bus.set_time);
  assign wrap     = bus.run & (presc == DIV_W'(CLK_DIV - 1));
  // A valid load on the wrap cycle swallows that second's increment.
  // An invalid load leaves counting exactly as if nothing had arrived.
  assign inc      = wrap & ~load_ok;
  assign cur_time = {hh_t, hh_u, mm_t, mm_u, ss_t, ss_u};
  assign hh_u_max = (hh_t == HOUR_MAX_T) ? HOUR_MAX_U_AT_2 : UNIT_MAX;
  assign alarm_ok = bcd_time_valid({bus.alarm_time, 8'h00});

  // Prescaler: cleared by a valid load, otherwise counts 0..CLK_DIV-1 while running.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (load_ok) begin
      presc <= '0;
    end else if (bus.run) begin
      presc <= wrap ? '0 : presc + DIV_W'(1);
    end
  end

  bcd_digit_ctr #(.MAX(UNIT_MAX)) u_ss_u (
    .clock(clock), .reset(reset), .inc(inc), .load(load_ok),
    .load_val(bus.set_time[3:0]), .max_dyn(UNIT_MAX),
    .digit(ss_u), .carry(cy_ss_u));

  bcd_digit_ctr #(.MAX(SEC_T_MAX)) u_ss_t (
    .clock(clock), .reset(reset), .inc(cy_ss_u), .load(load_ok),
    .load_val(bus.set_time[7:4]), .max_dyn(SEC_T_MAX),
    .digit(ss_t), .carry(cy_ss_t));

  bcd_digit_ctr #(.MAX(UNIT_MAX)) u_mm_u (
    .clock(clock), .reset(reset), .inc(cy_ss_t), .load(load_ok),
    .load_val(bus.set_time[11:8]), .max_dyn(UNIT_MAX),
    .digit(mm_u), .carry(cy_mm_u));

  bcd_digit_ctr #(.MAX(SEC_T_MAX)) u_mm_t (
    .clock(clock), .reset(reset), .inc(cy_mm_u), .load(load_ok),
    .load_val(bus.set_time[15:12]), .max_dyn(SEC_T_MAX),
    .digit(mm_t), .carry(cy_mm_t));

  // Hour units wrap at 3 in the twenties, at 9 otherwise.
  bcd_digit_ctr #(.MAX(UNIT_MAX), .DYN_MAX(1'b1)) u_hh_u (
    .clock(clock), .reset(reset), .inc(cy_mm_t), .load(load_ok),
    .load_val(bus.set_time[19:16]), .max_dyn(hh_u_max),
    .digit(hh_u), .carry(cy_hh_u));

  bcd_digit_ctr #(.MAX(HOUR_MAX_T)) u_hh_t (
    .clock(clock), .reset(reset), .inc(cy_hh_u), .load(load_ok),
    .load_val(bus.set_time[23:20]), .max_dyn(HOUR_MAX_T),
    .digit(hh_t), .carry(day_wrap_unused));

  // Handshake state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= LOAD_READY;
    else       state <= state_nxt;
  end

  // Handshake next state: a transfer makes the block busy for one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_READY: if (bus.set_valid) state_nxt = LOAD_BUSY;
      LOAD_BUSY:  state_nxt = LOAD_READY;
      default:    state_nxt = LOAD_READY;
    endcase
  end

  // 12-hour conversion of the hour pair, done in BCD without a binary detour.
  always_comb begin
    disp_hh = {hh_t, hh_u};
    disp_pm = 1'b0;
    if (bus.mode_12h) begin
      if (hh_t == 4'd0 && hh_u == 4'd0) begin
        disp_hh = 8'h12;
      end else if (hh_t == 4'd1 && hh_u == 4'd2) begin
        disp_pm = 1'b1;
      end else if (hh_t == 4'd1 && hh_u > 4'd2) begin
        disp_hh = {4'd0, hh_u - 4'd2};
        disp_pm = 1'b1;
      end else if (hh_t == 4'd2) begin
        disp_hh = (hh_u < 4'd2) ? {4'd0, hh_u + 4'd8} : {4'd1, hh_u - 4'd2};
        disp_pm = 1'b1;
      end
    end
  end

  // Output registers: display, status pulses and alarm match.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      time_bcd_r  <= RESET_TIME;
      pm_r        <= 1'b0;
      set_err_r   <= 1'b0;
      sec_tick_r  <= 1'b0;
      alarm_hit_r <= 1'b0;
    end else begin
      time_bcd_r  <= {disp_hh, mm_t, mm_u, ss_t, ss_u};
      pm_r        <= disp_pm;
      set_err_r   <= xfer & ~load_ok;
      sec_tick_r  <= inc;
      // sec_tick_r marks that the time now held came from an increment, not a load.
      alarm_hit_r <= bus.alarm_en & sec_tick_r & alarm_ok &
                     (cur_time == {bus.alarm_time, 8'h00});
    end
  end

  assign bus.set_ready = ready;
  assign bus.set_err   = set_err_r;
  assign bus.sec_tick  = sec_tick_r;
  assign bus.alarm_hit = alarm_hit_r;
  assign bus.time_bcd  = time_bcd_r;
  assign bus.pm        = pm_r;

endmodule
`default_nettype wire

// File: tb/tb_bcd_rtc.sv
`default_nettype none
// ============================================================================
// Module  : tb_bcd_rtc
// Self-checking bench for bcd_rtc with a seconds-of-day reference model.
// Revision: 1.0  initial release
// ============================================================================
module tb_bcd_rtc;

  localparam int CLK_DIV = 4;
  localparam int DAY     = 86400;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  bcd_rtc_if bus ();

  bcd_rtc #(.CLK_DIV(CLK_DIV)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  // Reference model state
  int          m_secs, m_p;
  bit          m_ready, m_err, m_tick, m_alarm, m_pm;
  logic [23:0] m_disp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dig(input logic [23:0] t, input int i);
    logic [3:0] d;
    d = t[i*4 +: 4];
    return int'(d);
  endfunction

  function automatic bit time_ok(input logic [23:0] t);
    for (int i = 0; i < 6; i++) if (dig(t, i) > 9) return 1'b0;
    if (dig(t, 1) > 5 || dig(t, 3) > 5) return 1'b0;
    return (dig(t, 5) * 10 + dig(t, 4)) <= 23;
  endfunction

  function automatic int to_secs(input logic [23:0] t);
    return (dig(t, 5) * 10 + dig(t, 4)) * 3600 + (dig(t, 3) * 10 + dig(t, 2)) * 60
           + dig(t, 1) * 10 + dig(t, 0);
  endfunction

  function automatic logic [23:0] hms_bcd(input int h, input int m, input int s);
    logic [23:0] r;
    r = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    return r;
  endfunction

  task automatic model_reset();
    m_secs = 0; m_p = 0; m_ready = 1; m_err = 0; m_tick = 0;
    m_alarm = 0; m_pm = 0; m_disp = 24'h0;
  endtask

  // One rising edge of the model, using inputs as they stand at the edge.
  task automatic model_step();
    int  h, old_secs;
    bit  old_tick, xfer, v;
    if (reset) begin
      model_reset();
      return;
    end
    old_secs = m_secs;
    old_tick = m_tick;
    h = old_secs / 3600;
    if (bus.mode_12h) begin
      m_pm   = (h >= 12);
      m_disp = hms_bcd((h % 12 == 0) ? 12 : h % 12, (old_secs / 60) % 60, old_secs % 60);
    end else begin
      m_pm   = 0;
      m_disp = hms_bcd(h, (old_secs / 60) % 60, old_secs % 60);
    end
    m_alarm = bus.alarm_en && old_tick && time_ok({bus.alarm_time, 8'h00}) &&
              (old_secs == to_secs({bus.alarm_time, 8'h00}));
    xfer   = bus.set_valid && m_ready;
    v      = time_ok(bus.set_time);
    m_err  = xfer && !v;
    m_tick = 0;
    if (xfer && v) begin
      m_secs = to_secs(bus.set_time);
      m_p    = 0;
    end else if (bus.run) begin
      if (m_p == CLK_DIV - 1) begin
        m_p    = 0;
        m_secs = (m_secs + 1) % DAY;
        m_tick = 1;
      end else begin
        m_p++;
      end
    end
    m_ready = !xfer;
  endtask

  task automatic compare_all();
    check("time_bcd",  bus.time_bcd,  m_disp);
    check("pm",        bus.pm,        m_pm);
    check("set_ready", bus.set_ready, m_ready);
    check("set_err",   bus.set_err,   m_err);
    check("sec_tick",  bus.sec_tick,  m_tick);
    check("alarm_hit", bus.alarm_hit, m_alarm);
  endtask

  // Edge, model update, compare just after the edge, return at the falling edge.
  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
    @(negedge clock);
  endtask

  task automatic load(input logic [23:0] t);
    bus.set_valid = 1'b1;
    bus.set_time  = t;
    cycle();
    bus.set_valid = 1'b0;
  endtask

  initial begin
    int          cnt, k, found;
    logic [23:0] rec;
    model_reset();
    bus.run = 0; bus.mode_12h = 0; bus.set_valid = 0; bus.set_time = 0;
    bus.alarm_en = 0; bus.alarm_time = 0;

    // Reset state
    @(negedge clock);
    cycle(); cycle();
    check("rst_ready", bus.set_ready, 1'b1);
    check("rst_time",  bus.time_bcd,  24'h000000);

    // First tick after CLK_DIV cycles, display one cycle later
    reset = 0; bus.run = 1;
    repeat (CLK_DIV) cycle();
    check("first_tick", bus.sec_tick, 1'b1);
    check("pre_disp",   bus.time_bcd, 24'h000000);
    cycle();
    check("first_disp", bus.time_bcd, 24'h000001);
    repeat (10) cycle();

    // Midnight rollover in 24h and 12h form
    load(24'h235958);
    repeat (5) cycle();
    check("roll24_a", bus.time_bcd, 24'h235959);
    repeat (4) cycle();
    check("roll24_b", bus.time_bcd, 24'h000000);
    bus.mode_12h = 1;
    load(24'h235958);
    repeat (5) cycle();
    check("roll12_a", bus.time_bcd, 24'h115959);
    check("roll12_pm", bus.pm, 1'b1);
    repeat (4) cycle();
    check("roll12_b", bus.time_bcd, 24'h120000);
    check("roll12_am", bus.pm, 1'b0);
    bus.mode_12h = 0;

    // Valid and invalid loads
    load(24'h123456);
    check("ld_busy", bus.set_ready, 1'b0);
    check("ld_noerr", bus.set_err, 1'b0);
    cycle();
    check("ld_ready", bus.set_ready, 1'b1);
    check("ld_time", bus.time_bcd, 24'h123456);
    load(24'h246000);
    check("bad_hour_err", bus.set_err, 1'b1);
    cycle();
    check("bad_hour_keep", bus.time_bcd[23:8], 16'h1234);
    load(24'h1A0000);
    check("bad_digit_err", bus.set_err, 1'b1);
    cycle();
    check("bad_digit_keep", bus.time_bcd[23:8], 16'h1234);

    // Load on the prescaler wrap cycle
    k = 0;
    while (m_p != CLK_DIV - 1 && k < 10) begin cycle(); k++; end
    check("wrap_reached", m_p, CLK_DIV - 1);
    load(24'h000010);
    check("wrap_notick", bus.sec_tick, 1'b0);
    found = 0;
    for (int i = 1; i <= 2 * CLK_DIV && found == 0; i++) begin
      cycle();
      if (bus.sec_tick) found = i;
    end
    check("tick_gap", found, CLK_DIV);

    // Alarm
    bus.alarm_time = 16'h0701; bus.alarm_en = 1;
    load(24'h070059);
    cnt = 0;
    repeat (8) begin cycle(); cnt += int'(bus.alarm_hit); end
    check("alarm_once", cnt, 1);
    bus.alarm_en = 0;
    load(24'h070059);
    cnt = 0;
    repeat (8) begin cycle(); cnt += int'(bus.alarm_hit); end
    check("alarm_off", cnt, 0);
    bus.alarm_en = 1;
    load(24'h070100);
    cnt = 0;
    repeat (8) begin cycle(); cnt += int'(bus.alarm_hit); end
    check("alarm_load", cnt, 0);
    bus.alarm_en = 0;

    // Freeze
    repeat (3) cycle();
    bus.run = 0;
    cycle();
    rec = bus.time_bcd;
    repeat (10) cycle();
    check("freeze", bus.time_bcd, rec);
    bus.run = 1;
    repeat (6) cycle();

    // Reset during a load
    bus.set_valid = 1; bus.set_time = 24'h101010;
    #2 reset = 1;
    #1;
    model_reset();
    compare_all();
    cycle();
    bus.set_valid = 0;
    cycle();
    reset = 0;
    check("rst_noerr", bus.set_err, 1'b0);
    repeat (3) cycle();

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      int hh, mm;
      bus.run      = ($urandom % 8) != 0;
      bus.mode_12h = $urandom % 2;
      bus.alarm_en = $urandom % 2;
      if ($urandom % 6 == 0) begin
        bus.set_valid = 1;
        if ($urandom % 2) bus.set_time = hms_bcd($urandom % 24, $urandom % 60, $urandom % 60);
        else              bus.set_time = 24'($urandom);
      end else begin
        bus.set_valid = 0;
      end
      if ($urandom % 16 == 0) begin
        mm = (m_secs / 60 + 1) % 1440;
        hh = mm / 60;
        rec = hms_bcd(hh, mm % 60, 0);
        bus.alarm_time = rec[23:8];
      end
      cycle();
    end
    bus.set_valid = 0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
